// File: rtl/lutnet_pkg.sv
// Shared definitions for runtime-loadable LogicNets neuron tables.
// Defaults match the generated fixed-ROM neuron modules.
package lutnet_pkg;

    localparam int LUT_IN_BITS  = 6;
    localparam int LUT_OUT_BITS = 2;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } lut_state_t;

    function automatic int lutDepth(input int inBits);
        return 1 << inBits;
    endfunction

endpackage

// File: rtl/lutnet_dist_ram.sv
// Truth-table storage: one synchronous write port, one registered read port.
// The array is small enough to live in LUT RAM rather than block RAM.
module lutnet_dist_ram #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 2
) (
    input  logic                 clk,
    input  logic                 i_wrEn,
    input  logic [ADDR_BITS-1:0] i_wrAddr,
    input  logic [DATA_BITS-1:0] i_wrData,
    input  logic [ADDR_BITS-1:0] i_rdAddr,
    output logic [DATA_BITS-1:0] o_rdData
);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        r_rdData <= r_mem[i_rdAddr];
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/lutnet_table_loader.sv
// Loads a neuron truth table from a valid/ready config stream and serves
// one-cycle lookups from it once a complete table has been received.
module lutnet_table_loader
    import lutnet_pkg::*;
#(
    parameter int IN_BITS  = LUT_IN_BITS,
    parameter int OUT_BITS = LUT_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [OUT_BITS-1:0] s_data,
    input  logic                s_last,
    input  logic                lk_valid,
    input  logic [IN_BITS-1:0]  lk_addr,
    output logic                res_valid,
    output logic [OUT_BITS-1:0] res_data,
    output logic                loaded,
    output logic                err_len
);

    localparam int                 DEPTH    = lutDepth(IN_BITS);
    localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(DEPTH - 1);

    lut_state_t           r_state;
    logic [IN_BITS-1:0]   r_wrCnt;
    logic                 r_sReady;
    logic                 r_resValid;
    logic                 r_resGate;
    logic                 r_errLen;

    logic                 w_accept;
    logic                 w_atLast;
    logic                 w_write;
    logic [OUT_BITS-1:0]  w_ramQ;

    assign w_accept = s_valid && r_sReady;
    assign w_atLast = (r_wrCnt == LAST_IDX);
    // A restart in the same cycle as a beat wins, so that beat is never stored.
    assign w_write  = w_accept && !cfg_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_wrCnt    <= '0;
            r_sReady   <= 1'b0;
            r_resValid <= 1'b0;
            r_resGate  <= 1'b0;
            r_errLen   <= 1'b0;
        end else begin
            r_resValid <= lk_valid;
            r_resGate  <= (r_state == ST_ACTIVE);
            if (cfg_start) begin
                r_state  <= ST_LOAD;
                r_wrCnt  <= '0;
                r_sReady <= 1'b1;
                r_errLen <= 1'b0;
            end else if (w_accept) begin
                r_wrCnt <= r_wrCnt + IN_BITS'(1);
                if (s_last != w_atLast) begin
                    r_state  <= ST_EMPTY;
                    r_sReady <= 1'b0;
                    r_errLen <= 1'b1;
                end else if (s_last) begin
                    r_state  <= ST_ACTIVE;
                    r_sReady <= 1'b0;
                end
            end
        end
    end

    lutnet_dist_ram #(
        .ADDR_BITS (IN_BITS),
        .DATA_BITS (OUT_BITS)
    ) u_ram (
        .clk      (clk),
        .i_wrEn   (w_write),
        .i_wrAddr (r_wrCnt),
        .i_wrData (s_data),
        .i_rdAddr (lk_addr),
        .o_rdData (w_ramQ)
    );

    assign s_ready   = r_sReady;
    assign res_valid = r_resValid;
    assign res_data  = r_resGate ? w_ramQ : '0;
    assign loaded    = (r_state == ST_ACTIVE);
    assign err_len   = r_errLen;

endmodule

// File: tb/tb_lutnet_table_loader.sv
// Self-checking bench for lutnet_table_loader: vector table, directed
// corner sequences and randomized loads checked against a table-level model.
module tb_lutnet_table_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] s_data = 2'd0;
    logic       s_last = 1'b0;
    logic       lk_valid = 1'b0;
    logic [5:0] lk_addr = 6'd0;
    logic       res_valid;
    logic [1:0] res_data;
    logic       loaded;
    logic       err_len;

    lutnet_table_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .lk_valid  (lk_valid),
        .lk_addr   (lk_addr),
        .res_valid (res_valid),
        .res_data  (res_data),
        .loaded    (loaded),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a committed table plus the queue of beats received in this load.
    logic [1:0] mTable [64];
    logic [1:0] mPend [$];
    logic       mLoading = 1'b0;
    logic       mActive = 1'b0;
    logic       mErr = 1'b0;
    logic       lastAccepted;
    logic [1:0] tbData [64];

    typedef struct {
        logic [5:0] addr;
        logic [1:0] expData;
    } vec_t;
    vec_t vecs [3];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic cfgV, input logic svV,
                                 input logic [1:0] sdV, input logic slV,
                                 input logic lvV, input logic [5:0] laV);
        logic       wasActive;
        logic       expRv;
        logic [1:0] expRd;
        rst = rstV; cfg_start = cfgV; s_valid = svV; s_data = sdV; s_last = slV;
        lk_valid = lvV; lk_addr = laV;
        @(posedge clk);
        wasActive = mActive;
        lastAccepted = 1'b0;
        if (rstV) begin
            mLoading = 0; mActive = 0; mErr = 0; mPend.delete();
            expRv = 0; expRd = 0;
        end else begin
            expRv = lvV;
            expRd = wasActive ? mTable[laV] : 2'd0;
            if (cfgV) begin
                mLoading = 1; mActive = 0; mErr = 0; mPend.delete();
            end else if (svV && mLoading) begin
                lastAccepted = 1'b1;
                mPend.push_back(sdV);
                if (slV) begin
                    if (mPend.size() == 64) begin
                        for (int i = 0; i < 64; i++) mTable[i] = mPend[i];
                        mActive = 1;
                    end else begin
                        mErr = 1;
                    end
                    mLoading = 0;
                end else if (mPend.size() == 64) begin
                    mErr = 1;
                    mLoading = 0;
                end
            end
        end
        #1;
        checkOutput("s_ready", {7'd0, s_ready}, {7'd0, mLoading});
        checkOutput("loaded", {7'd0, loaded}, {7'd0, mActive});
        checkOutput("err_len", {7'd0, err_len}, {7'd0, mErr});
        checkOutput("res_valid", {7'd0, res_valid}, {7'd0, expRv});
        if (lvV || rstV) checkOutput("res_data", {6'd0, res_data}, {6'd0, expRd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'd0, 0, 0, 6'd0);
    endtask

    task automatic startLoad();
        applyStimulus(0, 1, 0, 2'd0, 0, 0, 6'd0);
    endtask

    // Sends beats 0..n-1 of tbData; s_last on beat lastIdx (-1 for none).
    task automatic loadTable(input int n, input int lastIdx, input bit gaps,
                             input bit doLookup, input logic [5:0] la);
        for (int i = 0; i < n; i++) begin
            int tries = 0;
            do begin
                logic sv;
                sv = gaps ? logic'($urandom_range(0, 1)) : 1'b1;
                applyStimulus(0, 0, sv, tbData[i], (i == lastIdx), doLookup, la);
                tries++;
            end while (!lastAccepted && tries < 200);
            if (!lastAccepted) begin
                checks++;
                failures++;
                $display("[TB] FAIL load_timeout: beat %0d not accepted, s_ready=%0b", i, s_ready);
                return;
            end
        end
    endtask

    task automatic lookupAll();
        for (int a = 0; a < 64; a++) applyStimulus(0, 0, 0, 2'd0, 0, 1, 6'(a));
    endtask

    initial begin
        int rvCount;
        vecs[0] = '{addr: 6'h00, expData: 2'd0};
        vecs[1] = '{addr: 6'h05, expData: 2'd1};
        vecs[2] = '{addr: 6'h3F, expData: 2'd3};

        // Reset state
        applyStimulus(1, 0, 0, 2'd0, 0, 1, 6'd0);
        applyStimulus(1, 0, 0, 2'd0, 0, 0, 6'd0);
        checkOutput("rst_res_data", {6'd0, res_data}, 8'd0);
        idle(2);

        // Identity-mod-4 table, then vector lookups
        for (int i = 0; i < 64; i++) tbData[i] = 2'(i);
        startLoad();
        loadTable(64, 63, 0, 0, 6'd0);
        checkOutput("loaded_after_final", {7'd0, loaded}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 2'd0, 0, 1, vecs[i].addr);
            checkOutput("vec_res_data", {6'd0, res_data}, {6'd0, vecs[i].expData});
        end

        // All-zero table, 64 back-to-back lookups
        for (int i = 0; i < 64; i++) tbData[i] = 2'd0;
        startLoad();
        loadTable(64, 63, 0, 0, 6'd0);
        rvCount = 0;
        for (int a = 0; a < 64; a++) begin
            applyStimulus(0, 0, 0, 2'd0, 0, 1, 6'(a));
            if (res_valid) rvCount++;
        end
        checkOutput("rv_count", 8'(rvCount), 8'd64);
        idle(1);

        // s_last on beat 10
        for (int i = 0; i < 64; i++) tbData[i] = 2'($urandom_range(0, 3));
        startLoad();
        loadTable(11, 10, 0, 0, 6'd0);
        checkOutput("early_last_err", {7'd0, err_len}, 8'd1);
        checkOutput("early_last_loaded", {7'd0, loaded}, 8'd0);
        applyStimulus(0, 0, 0, 2'd0, 0, 1, 6'h0A);
        checkOutput("early_last_lookup", {6'd0, res_data}, 8'd0);

        // 64th beat without s_last
        startLoad();
        checkOutput("cfg_clears_err", {7'd0, err_len}, 8'd0);
        loadTable(64, -1, 0, 0, 6'd0);
        checkOutput("missing_last_err", {7'd0, err_len}, 8'd1);

        // Recover with a gapped random load; repeat it gapless and compare
        startLoad();
        checkOutput("cfg_clears_err2", {7'd0, err_len}, 8'd0);
        loadTable(64, 63, 1, 0, 6'd0);
        checkOutput("gapped_loaded", {7'd0, loaded}, 8'd1);
        lookupAll();
        startLoad();
        loadTable(64, 63, 0, 0, 6'd0);
        lookupAll();

        // Lookup of 0x3F every cycle across the final beat
        for (int i = 0; i < 64; i++) tbData[i] = 2'($urandom_range(0, 3));
        tbData[63] = 2'd2;
        startLoad();
        loadTable(64, 63, 1, 1, 6'h3F);
        checkOutput("final_cycle_lookup", {6'd0, res_data}, 8'd0);
        applyStimulus(0, 0, 0, 2'd0, 0, 1, 6'h3F);
        checkOutput("post_final_lookup", {6'd0, res_data}, 8'd2);

        // cfg_start while ACTIVE with a table of 3s
        for (int i = 0; i < 64; i++) tbData[i] = 2'd3;
        startLoad();
        loadTable(64, 63, 0, 0, 6'd0);
        applyStimulus(0, 0, 0, 2'd0, 0, 1, 6'h11);
        checkOutput("threes_lookup", {6'd0, res_data}, 8'd3);
        applyStimulus(0, 1, 0, 2'd0, 0, 1, 6'h12);
        checkOutput("cfg_cycle_lookup", {6'd0, res_data}, 8'd3);
        checkOutput("cfg_drops_loaded", {7'd0, loaded}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'd0, 0, 1, 6'($urandom_range(0, 63)));
            checkOutput("after_cfg_lookup", {6'd0, res_data}, 8'd0);
        end

        // Restart colliding with a beat: beat dropped, load still counts from 0
        for (int i = 0; i < 64; i++) tbData[i] = 2'($urandom_range(0, 3));
        applyStimulus(0, 1, 1, 2'd1, 0, 0, 6'd0);
        loadTable(64, 63, 0, 0, 6'd0);
        lookupAll();

        // Reset at beat 30
        startLoad();
        loadTable(30, -1, 0, 0, 6'd0);
        applyStimulus(1, 0, 1, 2'd1, 0, 1, 6'd3);
        checkOutput("midload_rst_ready", {7'd0, s_ready}, 8'd0);
        checkOutput("midload_rst_data", {6'd0, res_data}, 8'd0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 2'($urandom_range(0, 3)), 0, 0, 6'd0);
        checkOutput("no_accept_before_cfg", {7'd0, s_ready}, 8'd0);
        for (int i = 0; i < 64; i++) tbData[i] = 2'($urandom_range(0, 3));
        startLoad();
        loadTable(64, 63, 1, 0, 6'd0);
        lookupAll();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: bench did not complete, checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
